// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush and global hold.
// Latency: one cycle from IF_ID inputs to ID_EX outputs; PC_write/IF_ID_write are combinational.
// Backpressure: a load-use hazard injects one bubble and freezes upstream; hold freezes everything.
//
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   IF_ID_*              : decode-side instruction fields (valid, regs, data, ctrl)
//   flush, hold          : squash of the decode instruction / global freeze
//   ID_EX_*              : registered EX-side fields (rs1/rs2 feed the forwarding unit)
//   PC_write,IF_ID_write : 1 = upstream stages may advance
//   stall_cnt, flush_cnt : saturating event counters
module id_ex_hazard_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        IF_ID_valid,
   input  logic [4:0]  IF_ID_rs1,
   input  logic [4:0]  IF_ID_rs2,
   input  logic [4:0]  IF_ID_rd,
   input  logic        IF_ID_uses_rs1,
   input  logic        IF_ID_uses_rs2,
   input  logic [31:0] IF_ID_pc,
   input  logic [31:0] IF_ID_rs1_data,
   input  logic [31:0] IF_ID_rs2_data,
   input  logic [31:0] IF_ID_imm,
   input  logic [7:0]  IF_ID_ctrl,
   input  logic        flush,
   input  logic        hold,
   output logic        ID_EX_valid,
   output logic [4:0]  ID_EX_rs1,
   output logic [4:0]  ID_EX_rs2,
   output logic [4:0]  ID_EX_rd,
   output logic [31:0] ID_EX_pc,
   output logic [31:0] ID_EX_rs1_data,
   output logic [31:0] ID_EX_rs2_data,
   output logic [31:0] ID_EX_imm,
   output logic [7:0]  ID_EX_ctrl,
   output logic        PC_write,
   output logic        IF_ID_write,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic        valid_q,    valid_d;
   logic [4:0]  rs1_q,      rs1_d;
   logic [4:0]  rs2_q,      rs2_d;
   logic [4:0]  rd_q,       rd_d;
   logic [31:0] pc_q,       pc_d;
   logic [31:0] rs1_dat_q,  rs1_dat_d;
   logic [31:0] rs2_dat_q,  rs2_dat_d;
   logic [31:0] imm_q,      imm_d;
   logic [7:0]  ctrl_q,     ctrl_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic stall;
   logic rs1_hit;
   logic rs2_hit;

   // Hazard only when a real load in EX targets a non-zero register that the
   // decode instruction actually reads; writes to x0 never create a dependency.
   assign rs1_hit  = IF_ID_uses_rs1 && (IF_ID_rs1 == rd_q);
   assign rs2_hit  = IF_ID_uses_rs2 && (IF_ID_rs2 == rd_q);
   assign load_use = valid_q && ctrl_q[1] && (rd_q != 5'd0) && IF_ID_valid
                     && (rs1_hit || rs2_hit);

   // Flush squashes the dependent instruction anyway, and hold freezes the
   // pipe, so neither case needs a bubble of its own.
   assign stall       = load_use && !flush && !hold;
   assign PC_write    = !(stall || hold);
   assign IF_ID_write = !(stall || hold);

   always_comb begin
      valid_d     = valid_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      pc_d        = pc_q;
      rs1_dat_d   = rs1_dat_q;
      rs2_dat_d   = rs2_dat_q;
      imm_d       = imm_q;
      ctrl_d      = ctrl_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (flush || (!hold && stall)) begin
         // Bubble: everything cleared so nothing stale reaches forwarding.
         valid_d   = 1'b0;
         rs1_d     = 5'd0;
         rs2_d     = 5'd0;
         rd_d      = 5'd0;
         pc_d      = 32'd0;
         rs1_dat_d = 32'd0;
         rs2_dat_d = 32'd0;
         imm_d     = 32'd0;
         ctrl_d    = 8'd0;
      end else if (!hold) begin
         valid_d   = IF_ID_valid;
         rs1_d     = IF_ID_rs1;
         rs2_d     = IF_ID_rs2;
         rd_d      = IF_ID_rd;
         pc_d      = IF_ID_pc;
         rs1_dat_d = IF_ID_rs1_data;
         rs2_dat_d = IF_ID_rs2_data;
         imm_d     = IF_ID_imm;
         // Control is gated so an invalid slot can never write state downstream.
         ctrl_d    = IF_ID_valid ? IF_ID_ctrl : 8'd0;
      end

      // stall already excludes hold; flush counts even while held.
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (flush && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         rs1_q       <= 5'd0;
         rs2_q       <= 5'd0;
         rd_q        <= 5'd0;
         pc_q        <= 32'd0;
         rs1_dat_q   <= 32'd0;
         rs2_dat_q   <= 32'd0;
         imm_q       <= 32'd0;
         ctrl_q      <= 8'd0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         valid_q     <= valid_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         pc_q        <= pc_d;
         rs1_dat_q   <= rs1_dat_d;
         rs2_dat_q   <= rs2_dat_d;
         imm_q       <= imm_d;
         ctrl_q      <= ctrl_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ID_EX_valid    = valid_q;
   assign ID_EX_rs1      = rs1_q;
   assign ID_EX_rs2      = rs2_q;
   assign ID_EX_rd       = rd_q;
   assign ID_EX_pc       = pc_q;
   assign ID_EX_rs1_data = rs1_dat_q;
   assign ID_EX_rs2_data = rs2_dat_q;
   assign ID_EX_imm      = imm_q;
   assign ID_EX_ctrl     = ctrl_q;
   assign stall_cnt      = stall_cnt_q;
   assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: vector table plus saturation/reset sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit later or after the rising edge.
module tb_id_ex_hazard_reg;

   localparam logic [7:0]  LW  = 8'h2B;   // regwrite, memread, memtoreg, alusrc
   localparam logic [7:0]  ADD = 8'h81;   // regwrite, aluop=2
   localparam logic [31:0] K1  = 32'h0000_1000;
   localparam logic [31:0] K2  = 32'h0000_2000;
   localparam logic [31:0] KI  = 32'h0000_0030;

   logic        clk = 1'b0;
   logic        rst, IF_ID_valid, IF_ID_uses_rs1, IF_ID_uses_rs2, flush, hold;
   logic [4:0]  IF_ID_rs1, IF_ID_rs2, IF_ID_rd;
   logic [31:0] IF_ID_pc, IF_ID_rs1_data, IF_ID_rs2_data, IF_ID_imm;
   logic [7:0]  IF_ID_ctrl;
   logic        ID_EX_valid, PC_write, IF_ID_write;
   logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
   logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
   logic [7:0]  ID_EX_ctrl;
   logic [15:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;
   int cur    = -1;

   always #5 clk = ~clk;

   id_ex_hazard_reg dut (
      .clk(clk), .rst(rst),
      .IF_ID_valid(IF_ID_valid), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_rd(IF_ID_rd),
      .IF_ID_uses_rs1(IF_ID_uses_rs1), .IF_ID_uses_rs2(IF_ID_uses_rs2),
      .IF_ID_pc(IF_ID_pc), .IF_ID_rs1_data(IF_ID_rs1_data), .IF_ID_rs2_data(IF_ID_rs2_data),
      .IF_ID_imm(IF_ID_imm), .IF_ID_ctrl(IF_ID_ctrl), .flush(flush), .hold(hold),
      .ID_EX_valid(ID_EX_valid), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
      .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
      .ID_EX_imm(ID_EX_imm), .ID_EX_ctrl(ID_EX_ctrl), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic        rst, flush, hold, v, u1, u2;
      logic [4:0]  rs1, rs2, rd;
      logic [7:0]  ctrl;
      logic [31:0] pc;
      logic        e_pcw, e_v;
      logic [4:0]  e_rs1, e_rs2, e_rd;
      logic [7:0]  e_ctrl;
      logic [31:0] e_pc;
      logic [15:0] e_s, e_f;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic r, f, h, v, u1, u2,
                               input logic [4:0] rs1, rs2, rd, input logic [7:0] ctrl,
                               input logic [31:0] pc, input logic e_pcw, e_v,
                               input logic [4:0] e_rs1, e_rs2, e_rd, input logic [7:0] e_ctrl,
                               input logic [31:0] e_pc, input logic [15:0] e_s, e_f);
      vec_t t;
      t.rst = r; t.flush = f; t.hold = h; t.v = v; t.u1 = u1; t.u2 = u2;
      t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.ctrl = ctrl; t.pc = pc;
      t.e_pcw = e_pcw; t.e_v = e_v; t.e_rs1 = e_rs1; t.e_rs2 = e_rs2; t.e_rd = e_rd;
      t.e_ctrl = e_ctrl; t.e_pc = e_pc; t.e_s = e_s; t.e_f = e_f;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", nm, cur, act, exp_v);
      end
   endtask

   task automatic drive(input logic r, f, h, v, u1, u2, input logic [4:0] rs1, rs2, rd,
                        input logic [7:0] ctrl, input logic [31:0] pc);
      rst = r; flush = f; hold = h; IF_ID_valid = v; IF_ID_uses_rs1 = u1; IF_ID_uses_rs2 = u2;
      IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; IF_ID_rd = rd; IF_ID_ctrl = ctrl; IF_ID_pc = pc;
      IF_ID_rs1_data = pc + K1; IF_ID_rs2_data = pc + K2; IF_ID_imm = pc + KI;
   endtask

   int stalls_seen;

   initial begin
      // Hazard walk: load-use, no-false-stall cases, flush over hazard, hold, invalid slot.
      vecs[0]  = mk(1,1,1,1,1,0, 1,2,5,  LW, 100, 0, 0, 0,0,0,   8'h00,   0, 0,0);
      vecs[1]  = mk(0,0,0,1,1,0, 1,2,5,  LW, 100, 1, 1, 1,2,5,   LW,    100, 0,0);
      vecs[2]  = mk(0,0,0,1,1,1, 5,6,7, ADD, 104, 0, 0, 0,0,0,   8'h00,   0, 1,0);
      vecs[3]  = mk(0,0,0,1,1,1, 5,6,7, ADD, 104, 1, 1, 5,6,7,   ADD,   104, 1,0);
      vecs[4]  = mk(0,0,0,1,1,0, 5,0,0,  LW, 108, 1, 1, 5,0,0,   LW,    108, 1,0);
      vecs[5]  = mk(0,0,0,1,1,1, 0,0,8, ADD, 112, 1, 1, 0,0,8,   ADD,   112, 1,0);
      vecs[6]  = mk(0,0,0,1,1,0, 2,3,5,  LW, 116, 1, 1, 2,3,5,   LW,    116, 1,0);
      vecs[7]  = mk(0,0,0,1,1,0, 3,5,9, ADD, 120, 1, 1, 3,5,9,   ADD,   120, 1,0);
      vecs[8]  = mk(0,0,0,1,1,0, 1,2,5,  LW, 124, 1, 1, 1,2,5,   LW,    124, 1,0);
      vecs[9]  = mk(0,1,0,1,1,0, 5,2,7, ADD, 128, 1, 0, 0,0,0,   8'h00,   0, 1,1);
      vecs[10] = mk(0,0,0,1,1,1,10,4,11,ADD, 132, 1, 1,10,4,11,  ADD,   132, 1,1);
      vecs[11] = mk(0,0,1,1,1,1,12,4,13, LW, 136, 0, 1,10,4,11,  ADD,   132, 1,1);
      vecs[12] = mk(0,0,1,1,1,1,12,4,13, LW, 136, 0, 1,10,4,11,  ADD,   132, 1,1);
      vecs[13] = mk(0,0,1,1,1,1,12,4,13, LW, 136, 0, 1,10,4,11,  ADD,   132, 1,1);
      vecs[14] = mk(0,1,1,1,1,1,12,4,13, LW, 136, 0, 0, 0,0,0,   8'h00,   0, 1,2);
      vecs[15] = mk(0,0,0,1,1,1,12,4,13, LW, 136, 1, 1,12,4,13,  LW,    136, 1,2);
      vecs[16] = mk(0,0,0,0,1,0,14,4,15, LW, 140, 1, 0,14,4,15,  8'h00, 140, 1,2);
      vecs[17] = mk(0,0,0,1,1,0,15,4,1, ADD, 144, 1, 1,15,4,1,   ADD,   144, 1,2);

      drive(1,0,0,0,0,0, 0,0,0, 8'h00, 0);
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         cur = i;
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].flush, vecs[i].hold, vecs[i].v, vecs[i].u1, vecs[i].u2,
               vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].ctrl, vecs[i].pc);
         #1;
         chk("PC_write", {31'd0, PC_write}, {31'd0, vecs[i].e_pcw});
         chk("IF_ID_write", {31'd0, IF_ID_write}, {31'd0, vecs[i].e_pcw});
         @(posedge clk);
         #1;
         chk("ID_EX_valid", {31'd0, ID_EX_valid}, {31'd0, vecs[i].e_v});
         chk("ID_EX_rs1", {27'd0, ID_EX_rs1}, {27'd0, vecs[i].e_rs1});
         chk("ID_EX_rs2", {27'd0, ID_EX_rs2}, {27'd0, vecs[i].e_rs2});
         chk("ID_EX_rd", {27'd0, ID_EX_rd}, {27'd0, vecs[i].e_rd});
         chk("ID_EX_ctrl", {24'd0, ID_EX_ctrl}, {24'd0, vecs[i].e_ctrl});
         chk("ID_EX_pc", ID_EX_pc, vecs[i].e_pc);
         chk("ID_EX_rs1_data", ID_EX_rs1_data, (vecs[i].e_pc == 0) ? 32'd0 : vecs[i].e_pc + K1);
         chk("ID_EX_rs2_data", ID_EX_rs2_data, (vecs[i].e_pc == 0) ? 32'd0 : vecs[i].e_pc + K2);
         chk("ID_EX_imm", ID_EX_imm, (vecs[i].e_pc == 0) ? 32'd0 : vecs[i].e_pc + KI);
         chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, vecs[i].e_s});
         chk("flush_cnt", {16'd0, flush_cnt}, {16'd0, vecs[i].e_f});
      end

      // Saturation: preset stall counter near the top, then a load that reads
      // its own destination produces a stall every other cycle.
      cur = 100;
      @(negedge clk);
      force dut.stall_cnt_q = 16'hFFFE;
      #1;
      release dut.stall_cnt_q;
      #1;
      chk("stall_cnt_preset", {16'd0, stall_cnt}, 32'h0000_FFFE);
      drive(0,0,0,1,1,0, 5,2,5, LW, 200);
      stalls_seen = 0;
      for (int c = 0; c < 6; c++) begin
         cur = 101 + c;
         if (c != 0) @(negedge clk);
         #1;
         if (!PC_write) stalls_seen++;
         @(posedge clk);
         #1;
         if (c == 1) chk("stall_cnt_first", {16'd0, stall_cnt}, 32'h0000_FFFF);
      end
      chk("stalls_seen", stalls_seen, 3);
      chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
      chk("flush_cnt_kept", {16'd0, flush_cnt}, 32'd2);

      // Reset in the middle of a stall discards the pending hazard.
      cur = 110;
      @(negedge clk);
      #1;
      chk("PC_write_reload", {31'd0, PC_write}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("PC_write_stall", {31'd0, PC_write}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, ID_EX_valid}, 32'd0);
      chk("rst_rd", {27'd0, ID_EX_rd}, 32'd0);
      chk("rst_ctrl", {24'd0, ID_EX_ctrl}, 32'd0);
      chk("rst_pc", ID_EX_pc, 32'd0);
      chk("rst_rs1_data", ID_EX_rs1_data, 32'd0);
      chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
      cur = 111;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("PC_write_after_rst", {31'd0, PC_write}, 32'd1);
      @(posedge clk);
      #1;
      chk("post_rst_valid", {31'd0, ID_EX_valid}, 32'd1);
      chk("post_rst_rd", {27'd0, ID_EX_rd}, 32'd5);
      chk("post_rst_ctrl", {24'd0, ID_EX_ctrl}, {24'd0, LW});
      chk("post_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_hazard_reg.md
ID_EX_HAZARD_REG -- requirements
Module: id_ex_hazard_reg

Interface
REQ-001 SHALL have a single clock and synchronous active-high reset: clk in 1, posedge clock; rst in 1, synchronous, active-high reset.
REQ-002 SHALL accept decode-side inputs:
- IF_ID_valid in 1
- IF_ID_rs1, IF_ID_rs2, IF_ID_rd in 5 each
- IF_ID_uses_rs1, IF_ID_uses_rs2 in 1 each: the instruction reads that source.
REQ-003 SHALL accept decode-side data inputs: IF_ID_pc, IF_ID_rs1_data, IF_ID_rs2_data, IF_ID_imm in 32 each.
REQ-004 SHALL accept IF_ID_ctrl in 8, packed as:
- [0] regwrite, [1] memread, [2] memwrite, [3] memtoreg
- [4] branch, [5] alusrc, [7:6] aluop.
REQ-005 SHALL accept control inputs:
- flush in 1: taken branch or jump resolved downstream; squashes the decode instruction.
- hold in 1: global freeze, for example memory busy.
REQ-006 SHALL drive registered EX-side outputs: ID_EX_valid 1; ID_EX_rs1, ID_EX_rs2, ID_EX_rd 5; ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm 32; ID_EX_ctrl 8. ID_EX_rs1 and ID_EX_rs2 feed the forwarding unit.
REQ-007 SHALL drive combinational outputs PC_write out 1 and IF_ID_write out 1: 1 = upstream stages may advance.
REQ-008 SHALL drive stall_cnt out 16 and flush_cnt out 16: saturating event counters.

Function
REQ-009 SHALL compute load_use combinationally from registered state. It is asserted when all of the following hold:
- ID_EX_valid and ID_EX_ctrl[1]
- ID_EX_rd != 0
- IF_ID_valid
- (IF_ID_uses_rs1 and IF_ID_rs1 == ID_EX_rd) or (IF_ID_uses_rs2 and IF_ID_rs2 == ID_EX_rd).
REQ-010 SHALL compute stall = load_use and not flush and not hold.
REQ-011 SHALL drive PC_write = IF_ID_write = not (stall or hold).
REQ-012 SHALL apply the following register update priority on each rising clk edge:
- rst, then flush, then hold, then stall, then normal load.
REQ-013 On flush, the block SHALL load a bubble, regardless of hold or load_use. A bubble is ID_EX_valid=0, ID_EX_ctrl=0, ID_EX_rs1/rs2/rd=0, and data fields=0.
REQ-014 On hold without flush, the block SHALL retain every ID_EX register unchanged.
REQ-015 On stall, the block SHALL load a bubble as defined in REQ-013.
REQ-016 On normal load, the block SHALL copy every IF_ID field into its ID_EX counterpart.
- ID_EX_valid <= IF_ID_valid.
- ID_EX_ctrl <= IF_ID_valid ? IF_ID_ctrl : 0.
REQ-017 A single load-use hazard SHALL produce exactly one bubble cycle. The next cycle sees the bubble in ID_EX, so load_use deasserts and the held instruction enters EX.
REQ-018 Latency SHALL be one cycle from IF_ID inputs to ID_EX outputs; there is no combinational path from IF_ID data fields to ID_EX outputs.
REQ-019 A load writing x0 (ID_EX_rd=0) SHALL never cause a stall.
REQ-020 stall_cnt SHALL increment by 1 in each cycle where stall=1, and saturate at 16'hFFFF.
REQ-021 flush_cnt SHALL increment by 1 in each cycle where flush=1, including cycles with hold=1, and saturate at 16'hFFFF.
REQ-022 Counters SHALL not change during hold except as stated in REQ-021.

Reset
REQ-023 When rst=1 at a clk edge, the block SHALL clear all ID_EX outputs to 0 (bubble), and clear stall_cnt and flush_cnt to 0.
REQ-024 PC_write and IF_ID_write SHALL read 1 in the cycle after reset, provided hold=0.
REQ-025 rst SHALL override flush, hold, and load_use in the same cycle.
REQ-026 Reset asserted mid-stall SHALL discard the pending hazard.

Verification
REQ-027 Load-use: ID_EX holds lw x5 (ctrl[1]=1, rd=5), and IF_ID holds add with rs1=5, uses_rs1=1, valid=1.
-> PC_write=IF_ID_write=0 for one cycle.
-> Next cycle: ID_EX_valid=0, ID_EX_ctrl=0, stall_cnt=1.
-> The cycle after: the add appears in ID_EX with rs1=5.
REQ-028 No false stall:
- IF_ID rs2=5 with uses_rs2=0, or ID_EX_rd=0 with memread=1 -> PC_write stays 1, no bubble, stall_cnt unchanged.
REQ-029 Flush beats hazard: load_use conditions true and flush=1 in the same cycle.
-> PC_write=1.
-> Next cycle: ID_EX bubble, flush_cnt=1, stall_cnt=0.
REQ-030 Hold: hold=1 for 3 cycles with valid data in ID_EX.
-> ID_EX unchanged for all 3 cycles, PC_write=0, counters unchanged.
-> After hold drops, the next IF_ID instruction loads normally.
REQ-031 Saturation and reset:
- Preload stall_cnt to 16'hFFFE, then generate 3 stalls -> stall_cnt reads 16'hFFFF.
- Assert rst during a stall cycle -> all ID_EX outputs and both counters read 0 next cycle.
